// File: rtl/video_timing_pkg.sv
// video_timing_pkg
//   Shared types and constants for the scan-out path.
//   - pixel_t : 12-bit packed pixel {b[11:8], g[7:4], r[3:0]}
//   - 1280x720 CEA-861 default timing, derived totals, counter widths
//   - scan_state_t : FILL/RUN state of the scan-out sequencer
package video_timing_pkg;

  localparam int COLOUR_W = 4;
  localparam int PIXEL_W  = 3 * COLOUR_W;

  typedef struct packed {
    logic [COLOUR_W-1:0] b;
    logic [COLOUR_W-1:0] g;
    logic [COLOUR_W-1:0] r;
  } pixel_t;

  // 720p default timing (pixels / lines)
  localparam int H_ACTIVE_720P = 1280;
  localparam int H_FP_720P     = 110;
  localparam int H_SYNC_720P   = 40;
  localparam int H_BP_720P     = 220;
  localparam int V_ACTIVE_720P = 720;
  localparam int V_FP_720P     = 5;
  localparam int V_SYNC_720P   = 5;
  localparam int V_BP_720P     = 20;

  localparam int H_TOTAL_720P = H_ACTIVE_720P + H_FP_720P + H_SYNC_720P + H_BP_720P; // 1650
  localparam int V_TOTAL_720P = V_ACTIVE_720P + V_FP_720P + V_SYNC_720P + V_BP_720P; // 750

  // Counter widths are fixed so that any timing up to 2047x1023 fits.
  localparam int H_CNT_W = 11;
  localparam int V_CNT_W = 10;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo
//   Synchronous single-clock FIFO with registered read data.
//   Ports:
//     clk, reset_n        clock, asynchronous active-low reset (pointers/count only)
//     push, wr_data       write strobe and data
//     pop                 read strobe; rd_data is valid the cycle after a granted pop
//     rd_data             registered read data
//     count, full, empty  occupancy status from registered count
//   A push while full (and not popping) is dropped. A pop while empty is
//   granted only if a push arrives in the same cycle: the incoming word is
//   forwarded straight to rd_data and the count stays unchanged.
module pixel_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && (!empty || push);
  assign push_ok = push && (!full || pop_ok);

  // Storage and read port carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
    if (pop_ok) begin
      rd_data <= empty ? wr_data : mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_scanout.sv
// pixel_scanout
//   Buffers upstream pixels in a FIFO and drains them in raster order against
//   a CEA-861 style timing generator (default 1280x720).
//   Ports:
//     clk, reset_n            pixel clock, asynchronous active-low reset
//     write_data, write_ready pixel in and its push strobe
//     can_write               upstream may produce a pixel next cycle
//     vid_r/g/b, vid_hsync, vid_vsync, vid_de   registered video out
//     frame_start             pulse with the first active pixel of a frame
//     underflow, overflow     sticky error flags
//     clear_status            synchronous clear of both flags
//   Build option: define SCANOUT_OUTREG_EN to add a second output register on
//   all vid_* outputs and frame_start (latency 2 instead of 1).
module pixel_scanout
  import video_timing_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int PREFILL    = 32,
  parameter int H_ACTIVE   = H_ACTIVE_720P,
  parameter int H_FP       = H_FP_720P,
  parameter int H_SYNC     = H_SYNC_720P,
  parameter int H_BP       = H_BP_720P,
  parameter int V_ACTIVE   = V_ACTIVE_720P,
  parameter int V_FP       = V_FP_720P,
  parameter int V_SYNC     = V_SYNC_720P,
  parameter int V_BP       = V_BP_720P
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PIXEL_W-1:0]  write_data,
  input  logic                write_ready,
  output logic                can_write,
  output logic [COLOUR_W-1:0] vid_r,
  output logic [COLOUR_W-1:0] vid_g,
  output logic [COLOUR_W-1:0] vid_b,
  output logic                vid_hsync,
  output logic                vid_vsync,
  output logic                vid_de,
  output logic                frame_start,
  output logic                underflow,
  output logic                overflow,
  input  logic                clear_status
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [H_CNT_W-1:0] H_ACT      = H_CNT_W'(H_ACTIVE);
  localparam logic [H_CNT_W-1:0] H_SYNC_BEG = H_CNT_W'(H_ACTIVE + H_FP);
  localparam logic [H_CNT_W-1:0] H_SYNC_END = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [H_CNT_W-1:0] H_LAST     = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [V_CNT_W-1:0] V_ACT      = V_CNT_W'(V_ACTIVE);
  localparam logic [V_CNT_W-1:0] V_SYNC_BEG = V_CNT_W'(V_ACTIVE + V_FP);
  localparam logic [V_CNT_W-1:0] V_SYNC_END = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [V_CNT_W-1:0] V_LAST     = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  scan_state_t        state_reg, state_next;
  logic [H_CNT_W-1:0] h_reg, h_next;
  logic [V_CNT_W-1:0] v_reg, v_next;

  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  pixel_t             fifo_rd_data;

  logic               running;
  logic               active;
  logic               hsync_now;
  logic               vsync_now;
  logic               first_now;

  // First output stage: control bits registered alongside the FIFO read.
  logic               de_s1, hs_s1, vs_s1, fs_s1, pix_ok_s1;
  pixel_t             pix_s1;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIXEL_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (write_ready),
    .wr_data (write_data),
    .pop     (active),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign can_write = (fifo_count <= CNT_W'(FIFO_DEPTH - 2));

  always_comb begin
    running   = (state_reg == ST_RUN);
    active    = running && (h_reg < H_ACT) && (v_reg < V_ACT);
    hsync_now = running && (h_reg >= H_SYNC_BEG) && (h_reg < H_SYNC_END);
    vsync_now = running && (v_reg >= V_SYNC_BEG) && (v_reg < V_SYNC_END);
    first_now = active && (h_reg == '0) && (v_reg == '0);
  end

  always_comb begin
    state_next = state_reg;
    h_next     = h_reg;
    v_next     = v_reg;
    if (state_reg == ST_FILL) begin
      h_next = '0;
      v_next = '0;
      if (fifo_count >= CNT_W'(PREFILL)) state_next = ST_RUN;
    end else if (h_reg == H_LAST) begin
      h_next = '0;
      v_next = (v_reg == V_LAST) ? '0 : v_reg + V_CNT_W'(1);
    end else begin
      h_next = h_reg + H_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_FILL;
      h_reg     <= '0;
      v_reg     <= '0;
    end else begin
      state_reg <= state_next;
      h_reg     <= h_next;
      v_reg     <= v_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de_s1     <= 1'b0;
      hs_s1     <= 1'b0;
      vs_s1     <= 1'b0;
      fs_s1     <= 1'b0;
      pix_ok_s1 <= 1'b0;
    end else begin
      de_s1     <= active;
      hs_s1     <= hsync_now;
      vs_s1     <= vsync_now;
      fs_s1     <= first_now;
      // Read data is only meaningful when the pop was granted; an
      // underflowing pop leaves rd_data stale, so it is masked to black.
      pix_ok_s1 <= active && (!fifo_empty || write_ready);
    end
  end

  assign pix_s1 = pix_ok_s1 ? fifo_rd_data : '0;

  // Sticky flags: a new event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      underflow <= (underflow && !clear_status) || (active && fifo_empty && !write_ready);
      overflow  <= (overflow  && !clear_status) || (write_ready && fifo_full && !active);
    end
  end

`ifdef SCANOUT_OUTREG_EN
  logic   de_s2, hs_s2, vs_s2, fs_s2;
  pixel_t pix_s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de_s2  <= 1'b0;
      hs_s2  <= 1'b0;
      vs_s2  <= 1'b0;
      fs_s2  <= 1'b0;
      pix_s2 <= '0;
    end else begin
      de_s2  <= de_s1;
      hs_s2  <= hs_s1;
      vs_s2  <= vs_s1;
      fs_s2  <= fs_s1;
      pix_s2 <= pix_s1;
    end
  end

  assign vid_r       = pix_s2.r;
  assign vid_g       = pix_s2.g;
  assign vid_b       = pix_s2.b;
  assign vid_de      = de_s2;
  assign vid_hsync   = hs_s2;
  assign vid_vsync   = vs_s2;
  assign frame_start = fs_s2;
`else
  assign vid_r       = pix_s1.r;
  assign vid_g       = pix_s1.g;
  assign vid_b       = pix_s1.b;
  assign vid_de      = de_s1;
  assign vid_hsync   = hs_s1;
  assign vid_vsync   = vs_s1;
  assign frame_start = fs_s1;
`endif

endmodule

// File: tb/tb_pixel_scanout.sv
// tb_pixel_scanout
//   Randomised bench for pixel_scanout using a reduced raster so several
//   frames fit in a short run. The reference model tracks the FIFO as a
//   queue and the raster position as a single cycle index within the frame.
module tb_pixel_scanout;

  localparam int DEPTH   = 64;
  localparam int PREFILL = 32;
  localparam int HA = 20, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
`ifdef SCANOUT_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] write_data = '0;
  logic        write_ready = 1'b0;
  logic        clear_status = 1'b0;
  logic        can_write;
  logic [3:0]  vid_r, vid_g, vid_b;
  logic        vid_hsync, vid_vsync, vid_de, frame_start;
  logic        underflow, overflow;

  always #5 clk = ~clk;

  pixel_scanout #(
    .FIFO_DEPTH (DEPTH), .PREFILL (PREFILL),
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .write_data   (write_data),
    .write_ready  (write_ready),
    .can_write    (can_write),
    .vid_r        (vid_r),
    .vid_g        (vid_g),
    .vid_b        (vid_b),
    .vid_hsync    (vid_hsync),
    .vid_vsync    (vid_vsync),
    .vid_de       (vid_de),
    .frame_start  (frame_start),
    .underflow    (underflow),
    .overflow     (overflow),
    .clear_status (clear_status)
  );

  typedef struct {
    int de;
    int hs;
    int vs;
    int fs;
    int pix;
  } vid_t;

  // Reference model state
  int   q[$];
  bit   run_m;
  int   t;            // raster position the DUT counters hold for the next edge
  bit   uf_m, of_m;
  vid_t pipe[2];

  // Stimulus / bookkeeping
  int n_cmp, n_bad;
  int cyc, de_cnt, fs_last, n_fs;
  bit cw_prev, gate_on, force_wr, clr_req;
  int wr_pct;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs now on the pins.
  task automatic model_step();
    vid_t e;
    bit   take, uf_ev, of_ev;
    int   h, v, n_before;
    e = '{default: 0};
    n_before = q.size();
    take  = write_ready;
    uf_ev = 1'b0;
    of_ev = 1'b0;
    if (run_m) begin
      h = t % HT;
      v = (t / HT) % VT;
      e.hs = int'(h >= HA + HF && h < HA + HF + HS);
      e.vs = int'(v >= VA + VF && v < VA + VF + VS);
      if (h < HA && v < VA) begin
        e.de = 1;
        e.fs = int'(h == 0 && v == 0);
        if (q.size() > 0) e.pix = q.pop_front();
        else if (take) begin
          e.pix = int'(write_data);
          take = 1'b0;
        end else uf_ev = 1'b1;
      end
      t = (t + 1) % FRAME;
    end else if (n_before >= PREFILL) begin
      run_m = 1'b1;
      t = 0;
    end
    if (take) begin
      if (q.size() < DEPTH) q.push_back(int'(write_data));
      else of_ev = 1'b1;
    end
    uf_m = (uf_m && !clear_status) || uf_ev;
    of_m = (of_m && !clear_status) || of_ev;
    pipe[1] = pipe[0];
    pipe[0] = e;
  endtask

  // One clock: compare what the last edge produced, then drive the next edge.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    check("de",        int'(vid_de),      pipe[LAT-1].de);
    check("hsync",     int'(vid_hsync),   pipe[LAT-1].hs);
    check("vsync",     int'(vid_vsync),   pipe[LAT-1].vs);
    check("fstart",    int'(frame_start), pipe[LAT-1].fs);
    check("pixel",     int'({vid_b, vid_g, vid_r}), pipe[LAT-1].pix);
    check("underflow", int'(underflow),   int'(uf_m));
    check("overflow",  int'(overflow),    int'(of_m));
    check("can_write", int'(can_write),   int'(q.size() <= DEPTH - 2));
    if (frame_start) begin
      if (fs_last >= 0) begin
        check("frame_period", cyc - fs_last, FRAME);
        check("de_per_frame", de_cnt, HA * VA);
      end
      fs_last = cyc;
      de_cnt  = 0;
      n_fs++;
    end
    if (vid_de) de_cnt++;
    // Upstream registers its request one cycle after sampling can_write.
    write_ready  = force_wr || (gate_on && cw_prev && ($urandom_range(99) < wr_pct));
    cw_prev      = can_write;
    write_data   = 12'($urandom_range(4095));
    clear_status = clr_req;
    clr_req      = 1'b0;
    model_step();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n      = 1'b0;
    write_ready  = 1'b0;
    clear_status = 1'b0;
    force_wr     = 1'b0;
    #1;
    check("rst_de",     int'(vid_de), 0);
    check("rst_pixel",  int'({vid_b, vid_g, vid_r}), 0);
    check("rst_syncs",  int'({vid_hsync, vid_vsync, frame_start}), 0);
    check("rst_flags",  int'({underflow, overflow}), 0);
    check("rst_canwr",  int'(can_write), 1);
    q.delete();
    run_m = 1'b0; t = 0; uf_m = 1'b0; of_m = 1'b0;
    pipe[0] = '{default: 0};
    pipe[1] = '{default: 0};
    fs_last = -1; de_cnt = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    cw_prev = 1'b0;
    model_step();
  endtask

  task automatic wait_pos(input int v, input int h, input string tag);
    int k;
    k = 0;
    while (!(run_m && t % HT == h && (t / HT) % VT == v) && k < 3 * FRAME) begin
      cycle();
      k++;
    end
    check(tag, int'(run_m && t % HT == h && (t / HT) % VT == v), 1);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; n_fs = 0;
    gate_on = 1'b1; force_wr = 1'b0; clr_req = 1'b0; wr_pct = 85;

    apply_reset();
    $display("reset released, streaming %0d frames of %0dx%0d", 3, HA, VA);
    repeat (3 * FRAME + 200) cycle();
    check("frames_seen", int'(n_fs >= 3), 1);

    wait_pos(0, 0, "stall_align");
    gate_on = 1'b0;
    repeat (100) cycle();
    check("uf_after_stall", int'(underflow), 1);
    $display("upstream stalled 100 cycles, underflow=%0d", underflow);
    gate_on = 1'b1; wr_pct = 100;
    repeat (20) cycle();
    clr_req = 1'b1;
    repeat (3) cycle();
    check("uf_cleared", int'(underflow), 0);
    $display("clear_status applied, underflow=%0d", underflow);

    wr_pct = 85;
    wait_pos(2, HA / 2, "midline_align");
    $display("asserting reset mid-line");
    apply_reset();
    n_fs = 0;
    repeat (FRAME + 200) cycle();
    check("restart_frames", int'(n_fs >= 1), 1);

    apply_reset();
    force_wr = 1'b1;
    $display("forcing write_ready continuously");
    wait_pos(VA + 1, 0, "blank_align");
    check("of_forced", int'(overflow), 1);
    check("cw_when_full", int'(can_write), 0);
    force_wr = 1'b0;
    clr_req = 1'b1;
    repeat (4) cycle();
    check("of_cleared", int'(overflow), 0);
    repeat (FRAME) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
